reg_read_stage: RTL and testbench

- Decode / operand-fetch pipeline stage of the RV32I core.
- Accepts instructions from fetch over a valid/ready handshake and drives the 2r1w register file read ports combinationally.
- Snoops the writeback port for same-cycle bypass, and tracks in-flight destination registers in a 32-entry scoreboard to stall RAW hazards.
- Holds one decoded instruction with its operands and immediate in an output register toward execute.

---
 rtl/rv_pkg.sv | 57 +++++
 rtl/rv_imm_gen.sv | 30 +++
 rtl/reg_read_stage.sv | 166 ++++++++++++++++
 tb/tb_reg_read_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, instruction field positions and the
// per-opcode control decode used by the operand-fetch stage.
package rv_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam int OPC_MSB = 6;
  localparam int OPC_LSB = 0;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 7;
  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;

  typedef struct packed {
    logic writes;
    logic uses_rs1;
    logic uses_rs2;
    logic illegal;
  } dec_ctrl_t;

  function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opc);
    dec_ctrl_t c;
    c = '{writes: 1'b0, uses_rs1: 1'b0, uses_rs2: 1'b0, illegal: 1'b0};
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: c.writes = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        c.writes   = 1'b1;
        c.uses_rs1 = 1'b1;
      end
      OPC_OP: begin
        c.writes   = 1'b1;
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
      end
      OPC_MISCMEM, OPC_SYSTEM: c.illegal = 1'b0;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate extraction; OP and unsupported opcodes give 0,
// MISC-MEM/SYSTEM carry their I-format field.
module rv_imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] imm_s;

  // Select the immediate format from the opcode.
  always_comb begin
    imm_s = 32'd0;
    case (i_instr[OPC_MSB:OPC_LSB])
      OPC_LUI, OPC_AUIPC: imm_s = {i_instr[31:12], 12'd0};
      OPC_JAL:            imm_s = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      OPC_BRANCH:         imm_s = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      OPC_STORE:          imm_s = {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISCMEM, OPC_SYSTEM:
                          imm_s = {{21{i_instr[31]}}, i_instr[30:20]};
      default:            imm_s = 32'd0;
    endcase
  end

  assign o_imm = XLEN'($signed(imm_s));

endmodule

// File: rtl/reg_read_stage.sv
// RV32I decode / operand-fetch stage: register file read with writeback bypass,
// scoreboard-based RAW stall, and one output register toward execute.
module reg_read_stage
  import rv_pkg::*;
#(
  parameter int  XLEN  = 32,
  parameter int  NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_if_valid,
  output logic            o_if_ready,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [31:0]     i_if_instr,
  output logic [AW-1:0]   o_rf_rd1_addr,
  input  logic [XLEN-1:0] i_rf_rd1_data,
  output logic [AW-1:0]   o_rf_rd2_addr,
  input  logic [XLEN-1:0] i_rf_rd2_data,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_wb_en,
  input  logic            i_flush,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [31:0]     o_ex_instr,
  output logic [XLEN-1:0] o_ex_rs1_val,
  output logic [XLEN-1:0] o_ex_rs2_val,
  output logic [XLEN-1:0] o_ex_imm,
  output logic [AW-1:0]   o_ex_rd,
  output logic            o_ex_rd_we,
  output logic            o_ex_illegal
);

  dec_ctrl_t       ctrl_s;
  logic [AW-1:0]   rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0] imm_s, rs1_val_s, rs2_val_s;
  logic            wb_hit1_s, wb_hit2_s, raw1_s, raw2_s;
  logic            out_free_s, accept_s, issue_s, rd_we_s;

  logic [NREGS-1:0] busy_q, busy_d;
  logic             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_imm_q, ex_imm_d;
  logic [31:0]      ex_instr_q, ex_instr_d;
  logic [AW-1:0]    ex_rd_q, ex_rd_d;
  logic             ex_rd_we_q, ex_rd_we_d, ex_illegal_q, ex_illegal_d;

  assign ctrl_s  = decode_ctrl(i_if_instr[OPC_MSB:OPC_LSB]);
  assign rs1_s   = AW'(i_if_instr[RS1_MSB:RS1_LSB]);
  assign rs2_s   = AW'(i_if_instr[RS2_MSB:RS2_LSB]);
  assign rd_s    = AW'(i_if_instr[RD_MSB:RD_LSB]);
  assign rd_we_s = ctrl_s.writes && (rd_s != {AW{1'b0}});

  assign o_rf_rd1_addr = rs1_s;
  assign o_rf_rd2_addr = rs2_s;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (i_if_instr),
    .o_imm   (imm_s)
  );

  assign wb_hit1_s = i_wb_en && (i_wb_addr == rs1_s);
  assign wb_hit2_s = i_wb_en && (i_wb_addr == rs2_s);

  // Operand bypass: x0 is hardwired, a same-cycle writeback beats the stale file.
  always_comb begin
    rs1_val_s = i_rf_rd1_data;
    rs2_val_s = i_rf_rd2_data;
    if (rs1_s == {AW{1'b0}})  rs1_val_s = {XLEN{1'b0}};
    else if (wb_hit1_s)       rs1_val_s = i_wb_data;
    else                      rs1_val_s = i_rf_rd1_data;
    if (rs2_s == {AW{1'b0}})  rs2_val_s = {XLEN{1'b0}};
    else if (wb_hit2_s)       rs2_val_s = i_wb_data;
    else                      rs2_val_s = i_rf_rd2_data;
  end

  // A source is unsafe if already issued and not yet written back, or still held here.
  assign raw1_s = ctrl_s.uses_rs1 && (rs1_s != {AW{1'b0}}) &&
                  ((busy_q[rs1_s] && !wb_hit1_s) || (ex_valid_q && ex_rd_we_q && (ex_rd_q == rs1_s)));
  assign raw2_s = ctrl_s.uses_rs2 && (rs2_s != {AW{1'b0}}) &&
                  ((busy_q[rs2_s] && !wb_hit2_s) || (ex_valid_q && ex_rd_we_q && (ex_rd_q == rs2_s)));

  assign out_free_s = !ex_valid_q || (i_ex_ready && !i_flush);
  assign o_if_ready = out_free_s && !raw1_s && !raw2_s && !i_flush;
  assign accept_s   = i_if_valid && o_if_ready;
  assign issue_s    = ex_valid_q && i_ex_ready && !i_flush;

  // Output register next state: flush kills, accept loads, issue alone drains.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_instr_d   = ex_instr_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_rd_we_d   = ex_rd_we_q;
    ex_illegal_d = ex_illegal_q;
    if (i_flush) begin
      ex_valid_d = 1'b0;
    end else if (accept_s) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = i_if_pc;
      ex_instr_d   = i_if_instr;
      ex_rs1_d     = rs1_val_s;
      ex_rs2_d     = rs2_val_s;
      ex_imm_d     = imm_s;
      ex_rd_d      = ctrl_s.writes ? rd_s : {AW{1'b0}};
      ex_rd_we_d   = rd_we_s;
      ex_illegal_d = ctrl_s.illegal;
    end else if (issue_s) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // Scoreboard: writeback clears, issue sets, set wins on collision.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      busy_d[r] = (busy_q[r] && !(i_wb_en && (i_wb_addr == AW'(r)))) ||
                  (issue_s && ex_rd_we_q && (ex_rd_q == AW'(r)));
    end
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= {NREGS{1'b0}};
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= {XLEN{1'b0}};
      ex_instr_q   <= 32'd0;
      ex_rs1_q     <= {XLEN{1'b0}};
      ex_rs2_q     <= {XLEN{1'b0}};
      ex_imm_q     <= {XLEN{1'b0}};
      ex_rd_q      <= {AW{1'b0}};
      ex_rd_we_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_instr_q   <= ex_instr_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_rd_we_q   <= ex_rd_we_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign o_ex_valid   = ex_valid_q;
  assign o_ex_pc      = ex_pc_q;
  assign o_ex_instr   = ex_instr_q;
  assign o_ex_rs1_val = ex_rs1_q;
  assign o_ex_rs2_val = ex_rs2_q;
  assign o_ex_imm     = ex_imm_q;
  assign o_ex_rd      = ex_rd_q;
  assign o_ex_rd_we   = ex_rd_we_q;
  assign o_ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage: decode table, directed hazard/flush/reset
// sequences and a randomized run against a behavioural model.
module tb_reg_read_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_if_valid = 1'b0, i_wb_en = 1'b0, i_flush = 1'b0, i_ex_ready = 1'b0;
  logic [31:0] i_if_pc = 32'd0, i_if_instr = 32'd0, i_wb_data = 32'd0;
  logic [4:0]  i_wb_addr = 5'd0;
  logic [31:0] i_rf_rd1_data, i_rf_rd2_data;
  logic        o_if_ready, o_ex_valid, o_ex_rd_we, o_ex_illegal;
  logic [4:0]  o_rf_rd1_addr, o_rf_rd2_addr, o_ex_rd;
  logic [31:0] o_ex_pc, o_ex_instr, o_ex_rs1_val, o_ex_rs2_val, o_ex_imm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_read_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_valid(i_if_valid), .o_if_ready(o_if_ready), .i_if_pc(i_if_pc), .i_if_instr(i_if_instr),
    .o_rf_rd1_addr(o_rf_rd1_addr), .i_rf_rd1_data(i_rf_rd1_data),
    .o_rf_rd2_addr(o_rf_rd2_addr), .i_rf_rd2_data(i_rf_rd2_data),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_en(i_wb_en), .i_flush(i_flush),
    .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready), .o_ex_pc(o_ex_pc), .o_ex_instr(o_ex_instr),
    .o_ex_rs1_val(o_ex_rs1_val), .o_ex_rs2_val(o_ex_rs2_val), .o_ex_imm(o_ex_imm),
    .o_ex_rd(o_ex_rd), .o_ex_rd_we(o_ex_rd_we), .o_ex_illegal(o_ex_illegal)
  );

  // Register file: written through the writeback port, x0 reads zero.
  logic [31:0] rf [32];
  always @(posedge clk) if (i_wb_en && i_wb_addr != 5'd0) rf[i_wb_addr] <= i_wb_data;
  assign i_rf_rd1_data = (o_rf_rd1_addr == 5'd0) ? 32'd0 : rf[o_rf_rd1_addr];
  assign i_rf_rd2_data = (o_rf_rd2_addr == 5'd0) ? 32'd0 : rf[o_rf_rd2_addr];

  // ---------------- reference model ----------------
  typedef struct { bit writes; bit u1; bit u2; bit ill; logic [31:0] imm; } rdec_t;

  function automatic int sext(input int field, input int bits);
    return (field >= (1 << (bits - 1))) ? field - (1 << bits) : field;
  endfunction

  function automatic rdec_t ref_decode(input logic [31:0] ins);
    rdec_t d;
    d = '{writes: 0, u1: 0, u2: 0, ill: 0, imm: 32'd0};
    case (ins[6:0])
      7'h37, 7'h17: begin d.writes = 1; d.imm = ins & 32'hFFFF_F000; end
      7'h6F: begin d.writes = 1; d.imm = 2 * sext(int'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20); end
      7'h67, 7'h03, 7'h13: begin d.writes = 1; d.u1 = 1; d.imm = sext(int'(ins[31:20]), 12); end
      7'h63: begin d.u1 = 1; d.u2 = 1; d.imm = 2 * sext(int'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12); end
      7'h23: begin d.u1 = 1; d.u2 = 1; d.imm = sext(int'({ins[31:25], ins[11:7]}), 12); end
      7'h33: begin d.writes = 1; d.u1 = 1; d.u2 = 1; end
      7'h0F, 7'h73: d.imm = sext(int'(ins[31:20]), 12);
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  logic        m_valid, m_we, m_ill;
  logic [31:0] m_pc, m_instr, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd;
  int          last_iss [32];
  int          last_wb  [32];
  int          cyc;
  int          pend [$];
  bit          seen_ready;

  // busy: the most recent scoreboard event on r was an issue (ties: issue wins).
  function automatic bit busy(input int r);
    return (r != 0) && (last_iss[r] >= 0) && (last_iss[r] >= last_wb[r]);
  endfunction

  function automatic bit stalls(input logic [4:0] r);
    bit in_flight, held;
    in_flight = busy(int'(r)) && !(i_wb_en && i_wb_addr == r);
    held      = m_valid && m_we && (m_rd == r);
    return (r != 5'd0) && (in_flight || held);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (i_wb_en && i_wb_addr == r) return i_wb_data;
    return rf[r];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_we = 0; m_ill = 0; m_pc = 0; m_instr = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
    for (int r = 0; r < 32; r++) begin last_iss[r] = -1; last_wb[r] = -1; end
    pend.delete();
  endtask

  // One cycle: inputs already driven; check ready/addresses, clock, check outputs.
  task automatic step();
    rdec_t d;
    logic [4:0] r1, r2, rd;
    logic [31:0] v1, v2;
    bit exp_rdy, acc, iss;
    #1;
    d  = ref_decode(i_if_instr);
    r1 = i_if_instr[19:15]; r2 = i_if_instr[24:20]; rd = i_if_instr[11:7];
    exp_rdy = (!m_valid || (i_ex_ready && !i_flush)) && !i_flush &&
              !(d.u1 && stalls(r1)) && !(d.u2 && stalls(r2));
    chk("if_ready", {31'd0, o_if_ready}, {31'd0, exp_rdy});
    chk("rd1_addr", {27'd0, o_rf_rd1_addr}, {27'd0, r1});
    chk("rd2_addr", {27'd0, o_rf_rd2_addr}, {27'd0, r2});
    seen_ready = o_if_ready;
    acc = i_if_valid && exp_rdy;
    iss = m_valid && i_ex_ready && !i_flush;
    v1 = operand(r1); v2 = operand(r2);
    @(posedge clk);
    cyc++;
    if (i_wb_en && i_wb_addr != 5'd0) last_wb[i_wb_addr] = cyc;
    if (iss && m_we) begin last_iss[m_rd] = cyc; pend.push_back(int'(m_rd)); end
    if (i_flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_pc = i_if_pc; m_instr = i_if_instr; m_rs1 = v1; m_rs2 = v2; m_imm = d.imm;
      m_rd = d.writes ? rd : 5'd0; m_we = d.writes && (rd != 5'd0); m_ill = d.ill;
    end else if (iss) m_valid = 0;
    #1;
    chk("ex_valid",   {31'd0, o_ex_valid},   {31'd0, m_valid});
    chk("ex_pc",      o_ex_pc,      m_pc);
    chk("ex_instr",   o_ex_instr,   m_instr);
    chk("ex_rs1_val", o_ex_rs1_val, m_rs1);
    chk("ex_rs2_val", o_ex_rs2_val, m_rs2);
    chk("ex_imm",     o_ex_imm,     m_imm);
    chk("ex_rd",      {27'd0, o_ex_rd}, {27'd0, m_rd});
    chk("ex_rd_we",   {31'd0, o_ex_rd_we},   {31'd0, m_we});
    chk("ex_illegal", {31'd0, o_ex_illegal}, {31'd0, m_ill});
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    i_if_valid = 0; i_wb_en = 0; i_flush = 0; i_ex_ready = 0; i_if_instr = 32'd0;
    rst_n = 1'b0;
    #2;
    chk("rst_ex_valid", {31'd0, o_ex_valid}, 32'd0);
    chk("rst_ex_fields", o_ex_pc | o_ex_instr | o_ex_rs1_val | o_ex_rs2_val | o_ex_imm, 32'd0);
    chk("rst_ex_flags", {27'd0, o_ex_rd} | {31'd0, o_ex_rd_we} | {31'd0, o_ex_illegal}, 32'd0);
    chk("rst_if_ready", {31'd0, o_if_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic present(input logic [31:0] ins);
    i_if_valid = 1'b1; i_if_pc = i_if_pc + 32'd4; i_if_instr = ins;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 11)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  typedef struct { logic [31:0] instr; logic [31:0] imm; logic [4:0] rd; bit we; bit ill; } vec_t;
  vec_t vecs [11];

  initial begin
    vecs[0]  = '{32'h0050_0093, 32'h0000_0005,  5'd1, 1, 0}; // addi x1,x0,5
    vecs[1]  = '{32'h0041_8133, 32'h0000_0000,  5'd2, 1, 0}; // add x2,x3,x4
    vecs[2]  = '{32'h1234_52B7, 32'h1234_5000,  5'd5, 1, 0}; // lui x5,0x12345
    vecs[3]  = '{32'h0071_2223, 32'h0000_0004,  5'd0, 0, 0}; // sw x7,4(x2)
    vecs[4]  = '{32'hFE20_8EE3, 32'hFFFF_FFFC,  5'd0, 0, 0}; // beq x1,x2,-4
    vecs[5]  = '{32'h0080_00EF, 32'h0000_0008,  5'd1, 1, 0}; // jal x1,8
    vecs[6]  = '{32'h0000_1017, 32'h0000_1000,  5'd0, 0, 0}; // auipc x0,1
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0000,  5'd0, 0, 1}; // unsupported opcode
    vecs[8]  = '{32'hFFF0_A383, 32'hFFFF_FFFF,  5'd7, 1, 0}; // lw x7,-1(x1)
    vecs[9]  = '{32'h0FF0_000F, 32'h0000_00FF,  5'd0, 0, 0}; // fence
    vecs[10] = '{32'h0000_0073, 32'h0000_0000,  5'd0, 0, 0}; // ecall
    for (int r = 0; r < 32; r++) rf[r] <= 32'h1111_0000 | 32'(r);
    model_clear();
    cyc = 0;
    #1;

    for (int v = 0; v < 11; v++) begin
      do_reset();
      present(vecs[v].instr);
      step();
      i_if_valid = 1'b0;
      chk("tbl_imm",     o_ex_imm, vecs[v].imm);
      chk("tbl_rd",      {27'd0, o_ex_rd}, {27'd0, vecs[v].rd});
      chk("tbl_rd_we",   {31'd0, o_ex_rd_we}, {31'd0, vecs[v].we});
      chk("tbl_illegal", {31'd0, o_ex_illegal}, {31'd0, vecs[v].ill});
    end

    // Back-to-back stream with no hazards.
    do_reset(); i_ex_ready = 1'b1;
    present(32'h0050_0093); step();
    chk("s1_imm", o_ex_imm, 32'd5); chk("s1_rd", {27'd0, o_ex_rd}, 32'd1);
    present(32'h0041_8133); step();
    chk("s1_ready2", {31'd0, seen_ready}, 32'd1);
    chk("s1_rs1", o_ex_rs1_val, 32'h1111_0003); chk("s1_rs2", o_ex_rs2_val, 32'h1111_0004);

    // RAW on x5 resolved by same-cycle writeback bypass.
    do_reset(); i_ex_ready = 1'b1;
    present(32'h0010_0293); step();
    present(32'h0052_8333); step();
    chk("s2_stall_held", {31'd0, seen_ready}, 32'd0);
    step();
    chk("s2_stall_busy", {31'd0, seen_ready}, 32'd0);
    i_wb_en = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'd1; step();
    i_wb_en = 1'b0; i_if_valid = 1'b0;
    chk("s2_accept", {31'd0, seen_ready}, 32'd1);
    chk("s2_rs1", o_ex_rs1_val, 32'd1); chk("s2_rs2", o_ex_rs2_val, 32'd1);

    // lw held, dependent sw stalls through issue until x7 writes back.
    do_reset();
    present(32'h0000_A383); step();
    present(32'h0071_2223); step();
    chk("s3_held", {31'd0, seen_ready}, 32'd0);
    i_ex_ready = 1'b1; step();
    chk("s3_issue", {31'd0, seen_ready}, 32'd0);
    step();
    chk("s3_busy7", {31'd0, seen_ready}, 32'd0);
    i_wb_en = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'hDEAD_BEEF; step();
    i_wb_en = 1'b0; i_if_valid = 1'b0;
    chk("s3_accept", {31'd0, seen_ready}, 32'd1);
    chk("s3_rs2", o_ex_rs2_val, 32'hDEAD_BEEF);

    // Flush kills the held instruction without setting busy.
    do_reset();
    present(32'h0050_0093); step();
    i_flush = 1'b1; i_ex_ready = 1'b1; present(32'h0041_8133); step();
    chk("s4_no_accept", {31'd0, seen_ready}, 32'd0);
    chk("s4_killed", {31'd0, o_ex_valid}, 32'd0);
    i_flush = 1'b0; present(32'h0010_8133); step();
    chk("s4_x1_free", {31'd0, seen_ready}, 32'd1);

    // Issue setting x9 and writeback clearing x9 in the same cycle: set wins.
    do_reset();
    present(32'h0030_0493); step();
    i_if_valid = 1'b0; i_ex_ready = 1'b1; i_wb_en = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'h99; step();
    i_wb_en = 1'b0; present(32'h0004_8533); step();
    chk("s5_set_wins", {31'd0, seen_ready}, 32'd0);
    i_wb_en = 1'b1; i_wb_addr = 5'd9; step();
    i_wb_en = 1'b0; i_if_valid = 1'b0;
    chk("s5_release", {31'd0, seen_ready}, 32'd1);

    // Reset in the middle of operation with busy[3] set and the output valid.
    do_reset(); i_ex_ready = 1'b1;
    present(32'h0070_0193); step();
    present(32'h0010_8133); step();
    i_if_valid = 1'b0; i_ex_ready = 1'b0;
    do_reset();
    present(32'h0031_8233); step();
    chk("s6_after_reset", {31'd0, seen_ready}, 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      i_if_valid = ($urandom_range(0, 3) != 0);
      i_if_pc    = $urandom;
      i_if_instr = rand_instr();
      i_ex_ready = ($urandom_range(0, 3) != 0);
      i_flush    = ($urandom_range(0, 19) == 0);
      i_wb_data  = $urandom;
      i_wb_addr  = 5'($urandom);
      i_wb_en    = 1'b0;
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        i_wb_en = 1'b1; i_wb_addr = 5'(pend.pop_front());
      end else if ($urandom_range(0, 15) == 0) begin
        i_wb_en = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
